// File: rtl/life_engine_if.sv
// life_engine_if: VGA lookup, control pulses, cell write port and status for life_engine
interface life_engine_if #(
  parameter int W = 320,
  parameter int H = 240
);
  logic [9:0]           vga_x, vga_y;
  logic                 step, seed, wr_en, wr_data;
  logic [$clog2(W)-1:0] wr_x;
  logic [$clog2(H)-1:0] wr_y;
  logic                 busy;
  logic [15:0]          gen_count;
  logic [2:0]           rgb;
  modport master (
    output vga_x, vga_y, step, seed, wr_en, wr_data, wr_x, wr_y,
    input  busy, gen_count, rgb
  );
  modport slave (
    input  vga_x, vga_y, step, seed, wr_en, wr_data, wr_x, wr_y,
    output busy, gen_count, rgb
  );
endinterface

// File: rtl/life_engine.sv
// life_engine: double-buffered Game of Life (B3/S23) sweep engine with registered VGA pixel lookup
module life_engine #(
  parameter int          W           = 320,
  parameter int          H           = 240,
  parameter int          SCALE_SHIFT = 1,
  parameter int          WRAP        = 1,
  parameter logic [15:0] SEED_INIT   = 16'hACE1,
  parameter logic [2:0]  ALIVE_RGB   = 3'b111,
  parameter logic [2:0]  DEAD_RGB    = 3'b001,
  parameter logic [2:0]  BORDER_RGB  = 3'b000
) (
  input logic          clk,
  input logic          rst,
  life_engine_if.slave io_bus
);
  localparam int N  = W * H;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int AW = $clog2(N);
  typedef enum logic [2:0] {CLEAR, IDLE, SEED, RUN, SWAP} state_t;
  state_t          r_state, w_state_nx;
  logic [N-1:0]    r_bank [2];
  logic [N-1:0]    w_fr;
  logic            r_front, r_seeded;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [AW-1:0]   r_idx, w_nidx, w_widx, w_didx;
  logic [15:0]     r_lfsr, r_gen;
  logic [2:0]      r_rgb, w_rgb;
  logic [3:0]      w_cnt;
  logic [9:0]      w_cx, w_cy;
  logic            w_last, w_scan, w_busy, w_next, w_wr_ok, w_in;
  int              w_nx, w_ny;

  assign w_fr    = r_bank[r_front];
  assign w_last  = r_idx == AW'(N - 1);
  assign w_scan  = r_state == CLEAR || r_state == SEED || r_state == RUN;
  assign w_wr_ok = int'(io_bus.wr_x) < W && int'(io_bus.wr_y) < H;
  assign w_widx  = AW'(int'(io_bus.wr_y) * W + int'(io_bus.wr_x));
  assign w_cx    = io_bus.vga_x >> SCALE_SHIFT;
  assign w_cy    = io_bus.vga_y >> SCALE_SHIFT;
  assign w_in    = int'(w_cx) < W && int'(w_cy) < H;
  assign w_didx  = AW'(int'(w_cy) * W + int'(w_cx));
  assign w_rgb   = !w_in ? BORDER_RGB : w_fr[w_didx] ? ALIVE_RGB : DEAD_RGB;

  // neighbour count of the cell under the sweep, read from the front bank
  always_comb begin
    w_cnt  = '0;
    w_nx   = 0;
    w_ny   = 0;
    w_nidx = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        w_nx = int'(r_x) + dx;
        w_ny = int'(r_y) + dy;
        if (WRAP != 0) begin
          w_nx = w_nx < 0 ? W - 1 : w_nx >= W ? 0 : w_nx;
          w_ny = w_ny < 0 ? H - 1 : w_ny >= H ? 0 : w_ny;
        end
        w_nidx = AW'(w_ny * W + w_nx);
        if ((dx != 0 || dy != 0) && w_nx >= 0 && w_nx < W && w_ny >= 0 && w_ny < H)
          w_cnt = w_cnt + 4'(w_fr[w_nidx]);
      end
  end

  assign w_next = (w_cnt == 4'd3) | (w_fr[r_idx] & (w_cnt == 4'd2));

  always_ff @(posedge clk)
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_nx;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      CLEAR:    w_state_nx = w_last ? IDLE : CLEAR;
      IDLE:     w_state_nx = io_bus.seed ? SEED : io_bus.step ? RUN : IDLE;
      SEED,
      RUN:      w_state_nx = w_last ? SWAP : r_state;
      SWAP:     w_state_nx = IDLE;
      default:  w_state_nx = CLEAR;
    endcase
  end

  always_comb begin
    w_busy = r_state != IDLE;
  end

  assign io_bus.busy      = w_busy;
  assign io_bus.gen_count = r_gen;
  assign io_bus.rgb       = r_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_front   <= 1'b0;
      r_seeded  <= 1'b0;
      r_gen     <= '0;
      r_lfsr    <= SEED_INIT;
      r_rgb     <= '0;
      r_idx     <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_rgb <= w_rgb;
      r_idx <= w_scan && !w_last ? r_idx + 1'b1 : '0;
      r_x   <= w_scan && r_x != XW'(W - 1) ? r_x + 1'b1 : '0;
      r_y   <= !w_scan ? '0 : r_x != XW'(W - 1) ? r_y : r_y == YW'(H - 1) ? '0 : r_y + 1'b1;
      unique case (r_state)
        CLEAR: begin
          r_bank[0][r_idx] <= 1'b0;
          r_bank[1][r_idx] <= 1'b0;
        end
        IDLE: begin
          if (io_bus.wr_en && w_wr_ok) r_bank[r_front][w_widx] <= io_bus.wr_data;
          r_seeded <= io_bus.seed;
        end
        SEED: begin
          r_bank[~r_front][r_idx] <= r_lfsr[0];
          r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
        RUN: r_bank[~r_front][r_idx] <= w_next;
        SWAP: begin
          r_front <= ~r_front;
          r_gen   <= r_seeded ? '0 : r_gen + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of clear, blinker, wrap/no-wrap edges, pixel mapping, seed and abort
module tb_life_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;

  life_engine_if #(.W(8), .H(6)) b0 ();
  life_engine_if #(.W(8), .H(6)) b1 ();
  assign b1.vga_x   = b0.vga_x;
  assign b1.vga_y   = b0.vga_y;
  assign b1.step    = b0.step;
  assign b1.seed    = b0.seed;
  assign b1.wr_en   = b0.wr_en;
  assign b1.wr_x    = b0.wr_x;
  assign b1.wr_y    = b0.wr_y;
  assign b1.wr_data = b0.wr_data;

  life_engine #(.W(8), .H(6), .SCALE_SHIFT(1), .WRAP(1)) dut0 (.clk(clk), .rst(rst), .io_bus(b0));
  life_engine #(.W(8), .H(6), .SCALE_SHIFT(1), .WRAP(0)) dut1 (.clk(clk), .rst(rst), .io_bus(b1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic s_step, input logic s_seed);
    b0.step = s_step;
    b0.seed = s_seed;
    tick();
    b0.step = 1'b0;
    b0.seed = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input logic d);
    b0.wr_en   = 1'b1;
    b0.wr_x    = 3'(x);
    b0.wr_y    = 3'(y);
    b0.wr_data = d;
    tick();
    b0.wr_en = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (b0.busy && n < 500) begin
      n++;
      tick();
    end
  endtask

  task automatic read_pix(input int x, input int y, output logic [2:0] r0, output logic [2:0] r1);
    b0.vga_x = 10'(x);
    b0.vga_y = 10'(y);
    tick();
    r0 = b0.rgb;
    r1 = b1.rgb;
  endtask

  task automatic read_grid(output logic [63:0] a0, output logic [63:0] a1, output int badcol);
    logic [2:0] r0, r1;
    a0 = '0;
    a1 = '0;
    badcol = 0;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        read_pix(x * 2, y * 2, r0, r1);
        a0[y * 8 + x] = r0 == 3'b111;
        a1[y * 8 + x] = r1 == 3'b111;
        if (r0 != 3'b111 && r0 != 3'b001) badcol++;
      end
  endtask

  function automatic logic [63:0] c(input int x, input int y);
    return 64'd1 << (y * 8 + x);
  endfunction

  initial begin
    logic [63:0] a0, a1;
    logic [2:0]  p0, p1;
    int          n, n2, bc;
    b0.vga_x = '0; b0.vga_y = '0; b0.step = 1'b0; b0.seed = 1'b0;
    b0.wr_en = 1'b0; b0.wr_x = '0; b0.wr_y = '0; b0.wr_data = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(b0.busy), 64'd1);
    chk("rst_rgb", 64'(b0.rgb), 64'd0);
    chk("rst_gen", 64'(b0.gen_count), 64'd0);
    wait_idle(n);
    chk("clear_cycles", 64'(n), 64'd48);
    read_grid(a0, a1, bc);
    chk("clear_grid", a0, 64'd0);
    chk("clear_colour", 64'(bc), 64'd0);

    wr(3, 2, 1'b1); wr(3, 3, 1'b1); wr(3, 4, 1'b1);
    pulse(1'b1, 1'b0);
    wait_idle(n);
    chk("step_cycles", 64'(n), 64'd49);
    read_grid(a0, a1, bc);
    chk("blinker_h", a0, c(2, 3) | c(3, 3) | c(4, 3));
    chk("blinker_h_nowrap", a1, c(2, 3) | c(3, 3) | c(4, 3));
    chk("gen1", 64'(b0.gen_count), 64'd1);
    pulse(1'b1, 1'b0);
    wait_idle(n);
    read_grid(a0, a1, bc);
    chk("blinker_v", a0, c(3, 2) | c(3, 3) | c(3, 4));
    chk("gen2", 64'(b0.gen_count), 64'd2);

    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    chk("gen_after_rst", 64'(b0.gen_count), 64'd0);
    wr(0, 5, 1'b1); wr(0, 0, 1'b1); wr(0, 1, 1'b1);
    pulse(1'b1, 1'b0);
    wait_idle(n);
    read_grid(a0, a1, bc);
    chk("wrap_edge", a0, c(7, 0) | c(0, 0) | c(1, 0));
    chk("nowrap_edge", a1, 64'd0);

    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    wr(3, 2, 1'b1);
    read_pix(6, 4, p0, p1);
    chk("pix_6_4", 64'(p0), 64'h7);
    read_pix(7, 5, p0, p1);
    chk("pix_7_5", 64'(p0), 64'h7);
    read_pix(16, 0, p0, p1);
    chk("pix_border", 64'(p0), 64'h0);
    read_pix(0, 0, p0, p1);
    chk("pix_dead", 64'(p0), 64'h1);

    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    pulse(1'b1, 1'b0);
    wait_idle(n);
    chk("gen_before_seed", 64'(b0.gen_count), 64'd1);
    b0.seed = 1'b1;
    b0.step = 1'b1;
    tick();
    b0.seed = 1'b0;
    n = b0.busy ? 1 : 0;
    b0.wr_en = 1'b1; b0.wr_x = 3'd1; b0.wr_y = 3'd0; b0.wr_data = 1'b1;
    b0.step = 1'b1;
    tick();
    b0.wr_en = 1'b0;
    b0.step = 1'b0;
    wait_idle(n2);
    chk("seed_cycles", 64'(n + n2), 64'd49);
    tick();
    chk("step_not_queued", 64'(b0.busy), 64'd0);
    chk("seed_gen", 64'(b0.gen_count), 64'd0);
    read_pix(0, 0, p0, p1);
    chk("seed_cell00", 64'(p0), 64'h7);
    read_pix(2, 0, p0, p1);
    chk("seed_cell10", 64'(p0), 64'h1);

    pulse(1'b1, 1'b0);
    repeat (10) tick();
    chk("run_busy", 64'(b0.busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_gen", 64'(b0.gen_count), 64'd0);
    wait_idle(n);
    chk("abort_clear_cycles", 64'(n), 64'd48);
    read_grid(a0, a1, bc);
    chk("abort_grid", a0, 64'd0);
    chk("abort_colour", 64'(bc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
Parametrised Game of Life core with a double-buffered cell array, a generation sweep engine and a VGA pixel lookup. On each step request it computes the next generation with rule B3/S23 into the back bank, one cell per cycle, then swaps banks. The display path always reads the front bank and maps scaled VGA coordinates to a 3-bit colour. It sits between the VGA timing generator and the control or input logic.

Parameters:
W, 320, grid width in cells
H, 240, grid height in cells
SCALE_SHIFT, 1, VGA pixels per cell edge = 2^SCALE_SHIFT
WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid count as dead
SEED_INIT, 16'hACE1, LFSR value loaded at reset
ALIVE_RGB, 3'b111, colour of a live cell
DEAD_RGB, 3'b001, colour of a dead cell
BORDER_RGB, 3'b000, colour for pixels outside the grid

Ports:
clk  in  1  system clock; all logic runs on the rising edge
rst  in  1  synchronous, active-high reset
vga_x  in  10  current VGA pixel column
vga_y  in  10  current VGA pixel row
step  in  1  single-cycle pulse; start one generation
seed  in  1  single-cycle pulse; fill the grid with pseudo-random cells
wr_en  in  1  write a single cell in the front bank
wr_x  in  clog2(W)  cell column for the write
wr_y  in  clog2(H)  cell row for the write
wr_data  in  1  value to write (1 = alive)
busy  out  1  high in CLEAR, SEED, RUN and SWAP
gen_count  out  16  generations completed since the last seed or clear
rgb  out  3  pixel colour, registered

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state becomes CLEAR, front bank = 0, gen_count = 0, lfsr = SEED_INIT, rgb = 3'b000, busy = 1 from the first cycle after rst.
- rst asserted in any state, including mid-RUN or mid-SEED, aborts the operation and behaves exactly as reset.
- States: CLEAR, IDLE, SEED, RUN, SWAP.
- CLEAR:
  - Writes 0 to cell (x,y) in both banks, scanning row-major, one cell per cycle.
  - After cell (W-1,H-1) is written, go to IDLE.
  - Takes W*H cycles.
- IDLE:
  - seed = 1: go to SEED. seed has priority when step and seed are both high.
  - step = 1 (and seed = 0): go to RUN.
  - wr_en = 1: write wr_data to the front bank at (wr_x,wr_y) at the clock edge.
  - wr_en with wr_x >= W or wr_y >= H is ignored.
  - wr_en on the same edge as step or seed: the write takes effect first, then the state changes.
- Busy states: step, seed and wr_en are ignored while busy = 1. They are not queued.
- SEED:
  - Row-major scan. The back bank cell receives lfsr[0].
  - The LFSR then advances as a Fibonacci right shift with new msb = b0^b2^b3^b5.
  - After the last cell, go to SWAP with gen_count forced to 0.
  - The LFSR is not reloaded between seeds.
- RUN:
  - Row-major scan. Count the 8 neighbours of (x,y) in the front bank; the count is a 4-bit value.
  - Next state = (count == 3) | (alive & count == 2). Write it to the back bank.
  - WRAP = 1: x-1 at x = 0 is W-1, x+1 at x = W-1 is 0; same rule in y.
  - WRAP = 0: out-of-grid neighbours count as 0.
  - After the last cell, go to SWAP.
- SWAP (1 cycle):
  - Front bank select toggles.
  - gen_count increments by 1 (mod 2^16), except after SEED where it is 0.
  - Next state is IDLE.
- Latency:
  - step seen in IDLE -> busy high for exactly W*H + 1 cycles.
  - The new generation is visible on rgb in the cycle after busy falls.
- Display path:
  - cx = vga_x >> SCALE_SHIFT, cy = vga_y >> SCALE_SHIFT.
  - If cx >= W or cy >= H, rgb <= BORDER_RGB.
  - Otherwise rgb <= front[cy][cx] ? ALIVE_RGB : DEAD_RGB.
  - rgb is registered: 1 cycle latency from vga_x/vga_y.
  - Display reads are never stalled by RUN; the front bank is stable until SWAP.

Test Plan:
1. W=8, H=6, SCALE_SHIFT=1, WRAP=1; pulse rst -> busy high for 48 cycles then low; gen_count = 0; every in-grid rgb = 3'b001.
2. Write cells (3,2), (3,3), (3,4) alive, then pulse step -> busy high exactly 49 cycles; live cells are only (2,3), (3,3), (4,3); gen_count = 1. A second step restores the vertical blinker; gen_count = 2.
3. Live cells (0,5), (0,0), (0,1):
   - WRAP=1, step -> live cells (7,0), (0,0), (1,0).
   - WRAP=0, same pattern, step -> all cells dead.
4. Set (3,2) alive; drive vga=(6,4) -> one cycle later rgb = 3'b111. Drive vga=(7,5) -> rgb = 3'b111. Drive vga=(16,0) -> rgb = 3'b000. Drive vga=(0,0) -> rgb = 3'b001.
5. Pulse seed and step in the same cycle -> seed wins; busy high 49 cycles; cell (0,0) = 1, cell (1,0) = 0; gen_count = 0. A wr_en during busy leaves the target cell unchanged.
6. Pulse step, then assert rst 10 cycles into RUN -> CLEAR runs for 48 cycles; all cells dead; gen_count = 0; busy falls at the end of CLEAR.
